// File: rtl/dvi_pkg.sv
// Shared DVI timing package: default 640x480@60 timing, raster totals,
// sync polarity constants and the raster region flag bundle.
package dvi_pkg;

  // Default 640x480@60 timing (25.175 MHz pixel clock)
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Sync polarity encodings
  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  // Region flags decoded from the raster counters
  typedef struct packed {
    logic h_active;
    logic h_sync;
    logic v_active;
    logic v_sync;
  } raster_flags_t;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/dvi_raster_cnt.sv
// Horizontal/vertical raster counters with enable and wrap, plus region
// flags decoded from the current counter values.
module dvi_raster_cnt
  import dvi_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CW       = 12
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  output logic [CW-1:0] o_h_cnt,
  output logic [CW-1:0] o_v_cnt,
  output raster_flags_t o_flags
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // Inclusive region bounds; inclusive ends always fit in CW bits
  localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST      = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_LAST  = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] V_ACT_LAST  = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] H_SYNC_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_LAST = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] V_SYNC_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_LAST = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;

  // Next-count: advance on enable, line wrap bumps v, frame wrap on same cycle
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (i_en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  // Counter registers; reset wins over enable
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Region decode on the current counters; vertical flags change only with v
  always_comb begin
    o_flags.h_active = (h_cnt_q <= H_ACT_LAST);
    o_flags.h_sync   = (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q <= H_SYNC_LAST);
    o_flags.v_active = (v_cnt_q <= V_ACT_LAST);
    o_flags.v_sync   = (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q <= V_SYNC_LAST);
  end

  assign o_h_cnt = h_cnt_q;
  assign o_v_cnt = v_cnt_q;

endmodule

// File: rtl/dvi_timing_gen.sv
// Video timing and checkerboard source feeding dvi_encoder.
// Optional build macro DVI_TIMING_BORDER_EN adds a 1-pixel white frame
// around the active area; timing is unchanged by it.
// i_en is a plain advance qualifier with no backpressure: high moves the
// raster one pixel per clock, low freezes counters and every output.
module dvi_timing_gen
  import dvi_pkg::*;
#(
  parameter int   H_ACTIVE   = DEF_H_ACTIVE,
  parameter int   H_FP       = DEF_H_FP,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BP       = DEF_H_BP,
  parameter int   V_ACTIVE   = DEF_V_ACTIVE,
  parameter int   V_FP       = DEF_V_FP,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BP       = DEF_V_BP,
  parameter logic HS_POL     = SYNC_ACTIVE_LOW,
  parameter logic VS_POL     = SYNC_ACTIVE_LOW,
  parameter int   CHECK_LOG2 = 5,
  parameter int   CW         = 12
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  output logic          o_pix,
  output logic          o_de,
  output logic          o_hs,
  output logic          o_vs,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_sof
);

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  raster_flags_t flags;

  dvi_raster_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CW       (CW)
  ) u_raster (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (i_en),
    .o_h_cnt (h_cnt),
    .o_v_cnt (v_cnt),
    .o_flags (flags)
  );

`ifdef DVI_TIMING_BORDER_EN
  localparam logic [CW-1:0] X_LAST = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(V_ACTIVE - 1);
`endif

  logic          pix_q, pix_d;
  logic          de_q, de_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          sof_q, sof_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;

  // Output decode from this cycle's counters; everything holds while disabled
  always_comb begin
    pix_d = pix_q;
    de_d  = de_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    sof_d = sof_q;
    x_d   = x_q;
    y_d   = y_q;
    if (i_en) begin
      de_d  = flags.h_active & flags.v_active;
      hs_d  = flags.h_sync ? HS_POL : ~HS_POL;
      vs_d  = flags.v_sync ? VS_POL : ~VS_POL;
      sof_d = (h_cnt == '0) && (v_cnt == '0);
      x_d   = h_cnt;
      y_d   = v_cnt;
      pix_d = de_d & (h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]);
`ifdef DVI_TIMING_BORDER_EN
      if (de_d && ((h_cnt == '0) || (h_cnt == X_LAST) ||
                   (v_cnt == '0) || (v_cnt == Y_LAST))) begin
        pix_d = 1'b1;
      end
`endif
    end
  end

  // Output registers; reset drives syncs to their inactive level
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pix_q <= 1'b0;
      de_q  <= 1'b0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      sof_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      pix_q <= pix_d;
      de_q  <= de_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      sof_q <= sof_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

  assign o_pix = pix_q;
  assign o_de  = de_q;
  assign o_hs  = hs_q;
  assign o_vs  = vs_q;
  assign o_sof = sof_q;
  assign o_x   = x_q;
  assign o_y   = y_q;

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Bench for dvi_timing_gen: three small raster configurations driven from
// one clock/reset/enable, a per-cycle expected-output model plus directed
// hand-computed checks on sync, enable, pattern, freeze and reset behaviour.
module tb_dvi_timing_gen;

  localparam int NI = 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic        pix_w [NI];
  logic        de_w  [NI];
  logic        hs_w  [NI];
  logic        vs_w  [NI];
  logic        sof_w [NI];
  logic [11:0] x_w   [NI];
  logic [11:0] y_w   [NI];

  // a: H 4/1/2/1, V 3/1/1/1, 2-pixel checks
  dvi_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CHECK_LOG2(1), .CW(12)
  ) u_a (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .o_pix(pix_w[0]), .o_de(de_w[0]), .o_hs(hs_w[0]), .o_vs(vs_w[0]),
    .o_x(x_w[0]), .o_y(y_w[0]), .o_sof(sof_w[0])
  );

  // b: H 8/1/2/1, V 4/1/1/1, 2-pixel checks
  dvi_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CHECK_LOG2(1), .CW(12)
  ) u_b (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .o_pix(pix_w[1]), .o_de(de_w[1]), .o_hs(hs_w[1]), .o_vs(vs_w[1]),
    .o_x(x_w[1]), .o_y(y_w[1]), .o_sof(sof_w[1])
  );

  // c: small config, 32-pixel checks (border-only pattern when enabled)
  dvi_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CHECK_LOG2(5), .CW(12)
  ) u_c (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .o_pix(pix_w[2]), .o_de(de_w[2]), .o_hs(hs_w[2]), .o_vs(vs_w[2]),
    .o_x(x_w[2]), .o_y(y_w[2]), .o_sof(sof_w[2])
  );

  // ---------------- model tables ----------------
  int p_ha [NI] = '{4, 8, 4};
  int p_hfp[NI] = '{1, 1, 1};
  int p_hs [NI] = '{2, 2, 2};
  int p_hbp[NI] = '{1, 1, 1};
  int p_va [NI] = '{3, 4, 3};
  int p_vfp[NI] = '{1, 1, 1};
  int p_vs [NI] = '{1, 1, 1};
  int p_vbp[NI] = '{1, 1, 1};
  int p_cl [NI] = '{1, 1, 5};

  int          mh   [NI];
  int          mv   [NI];
  logic [28:0] exp_o[NI];

  // Packed layout: {pix, de, hs, vs, sof, x[11:0], y[11:0]}
  localparam logic [28:0] RST_VAL = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'd0, 12'd0};

  function automatic logic [28:0] model_out(input int i, input int h, input int v);
    logic de, hs, vs, pix, sof;
    de  = (h < p_ha[i]) && (v < p_va[i]);
    hs  = !((h >= p_ha[i] + p_hfp[i]) && (h < p_ha[i] + p_hfp[i] + p_hs[i]));
    vs  = !((v >= p_va[i] + p_vfp[i]) && (v < p_va[i] + p_vfp[i] + p_vs[i]));
    pix = de && (h[p_cl[i]] != v[p_cl[i]]);
`ifdef DVI_TIMING_BORDER_EN
    if (de && (h == 0 || h == p_ha[i] - 1 || v == 0 || v == p_va[i] - 1)) pix = 1'b1;
`endif
    sof = (h == 0) && (v == 0);
    return {pix, de, hs, vs, sof, 12'(h), 12'(v)};
  endfunction

  task automatic model_edge(input int i);
    if (rst) begin
      exp_o[i] = RST_VAL;
      mh[i] = 0;
      mv[i] = 0;
    end else if (en) begin
      exp_o[i] = model_out(i, mh[i], mv[i]);
      mh[i]++;
      if (mh[i] == p_ha[i] + p_hfp[i] + p_hs[i] + p_hbp[i]) begin
        mh[i] = 0;
        mv[i]++;
        if (mv[i] == p_va[i] + p_vfp[i] + p_vs[i] + p_vbp[i]) mv[i] = 0;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_edge(i);
    #1;
    for (int i = 0; i < NI; i++)
      check($sformatf("model%0d", i),
            {3'b0, pix_w[i], de_w[i], hs_w[i], vs_w[i], sof_w[i], x_w[i], y_w[i]},
            {3'b0, exp_o[i]});
  endtask

  function automatic int exp_x(input int i);
    return int'(exp_o[i][23:12]);
  endfunction

  function automatic int exp_y(input int i);
    return int'(exp_o[i][11:0]);
  endfunction

  // ---------------- history for directed checks ----------------
  logic a_de [100];
  logic a_hs [100];
  logic a_vs [100];
  logic a_sof[100];
  logic b_pix[100];

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int cnt;
    int first;
    int n;
    logic [7:0] vec;
    logic [7:0] want_l0, want_l2;

    for (int i = 0; i < NI; i++) begin
      mh[i] = 0;
      mv[i] = 0;
      exp_o[i] = RST_VAL;
    end
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) tick();
    check("rst_de",  {31'd0, de_w[0]}, 32'd0);
    check("rst_hs",  {31'd0, hs_w[0]}, 32'd1);
    check("rst_sof", {31'd0, sof_w[0]}, 32'd0);

    // Release reset: first sample shows (0,0)
    rst = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      a_de[k]  = de_w[0];
      a_hs[k]  = hs_w[0];
      a_vs[k]  = vs_w[0];
      a_sof[k] = sof_w[0];
      b_pix[k] = pix_w[1];
    end
    check("sof_first", {31'd0, a_sof[0]}, 32'd1);
    check("de_first",  {31'd0, a_de[0]}, 32'd1);

    cnt = 0;
    for (int k = 0; k < 8; k++) cnt += int'(a_de[k]);
    check("de_line0_cnt", cnt, 4);
    cnt = 0;
    for (int k = 0; k < 48; k++) cnt += int'(a_de[k]);
    check("de_frame_cnt", cnt, 12);
    cnt = 0;
    for (int k = 24; k < 48; k++) cnt += int'(a_de[k]);
    check("de_vblank_cnt", cnt, 0);

    for (int k = 0; k < 8; k++) vec[k] = a_hs[k];
    check("hs_line0", {24'd0, vec}, 32'h9F);

    cnt = 0;
    first = -1;
    for (int k = 0; k < 48; k++) begin
      if (!a_vs[k]) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    check("vs_low_cnt", cnt, 8);
    check("vs_low_first", first, 32);

    cnt = 0;
    for (int k = 0; k < 48; k++) cnt += int'(a_sof[k]);
    check("sof_per_frame", cnt, 1);
    check("sof_period", {31'd0, a_sof[48]}, 32'd1);

`ifdef DVI_TIMING_BORDER_EN
    want_l0 = 8'hFF;
    want_l2 = 8'hB3;
`else
    want_l0 = 8'hCC;
    want_l2 = 8'h33;
`endif
    for (int k = 0; k < 8; k++) vec[k] = b_pix[k];
    check("pix_line0", {24'd0, vec}, {24'd0, want_l0});
    for (int k = 0; k < 8; k++) vec[k] = b_pix[24 + k];
    check("pix_line2", {24'd0, vec}, {24'd0, want_l2});
    cnt = 0;
    for (int k = 0; k < 84; k++)
      if ((k % 12) >= 8 || (k / 12) >= 4) cnt += int'(b_pix[k]);
    check("pix_blank", cnt, 0);

    // Freeze for 5 cycles while instance a shows x=2 in active video
    n = 0;
    while (!(exp_x(0) == 2 && exp_o[0][27]) && n < 100) begin
      tick();
      n++;
    end
    if (n == 100) check("wait_x2", 0, 1);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("frz_x", {20'd0, x_w[0]}, 32'd2);
      check("frz_de", {31'd0, de_w[0]}, 32'd1);
    end
    en = 1'b1;
    tick();
    check("resume_x", {20'd0, x_w[0]}, 32'd3);

    // Reset mid-frame at (2,1)
    n = 0;
    while (!(exp_x(0) == 2 && exp_y(0) == 1) && n < 100) begin
      tick();
      n++;
    end
    if (n == 100) check("wait_x2y1", 0, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_x", {20'd0, x_w[0]}, 32'd0);
    check("mid_rst_de", {31'd0, de_w[0]}, 32'd0);
    check("mid_rst_hs", {31'd0, hs_w[0]}, 32'd1);
    rst = 1'b0;
    tick();
    check("post_rst_sof", {31'd0, sof_w[0]}, 32'd1);
    check("post_rst_x", {20'd0, x_w[0]}, 32'd0);
    check("post_rst_y", {20'd0, y_w[0]}, 32'd0);

    // Reset beats a low enable
    repeat (7) tick();
    en  = 1'b0;
    rst = 1'b1;
    tick();
    check("rst_pri_y", {20'd0, y_w[0]}, 32'd0);
    check("rst_pri_x", {20'd0, x_w[0]}, 32'd0);
    rst = 1'b0;
    en  = 1'b1;
    tick();
    check("rst_pri_sof", {31'd0, sof_w[0]}, 32'd1);

    // Random enable gaps with occasional resets
    for (int k = 0; k < 300; k++) begin
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 80) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dvi_timing_gen.md
Name: dvi_timing_gen

Overview:
Video timing and test-pattern source directly upstream of dvi_encoder. It generates the raster (pixel/line counters) and drives 1-bit pixel, data-enable, hsync and vsync. Outputs connect straight to dvi_encoder i_pix/i_de/i_hs/i_vs in the same pixel-clock domain. Defaults give 640x480@60 (25.175 MHz pixel clock).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
CHECK_LOG2, 5, checkerboard square size = 2^CHECK_LOG2 pixels
CW, 12, width of o_x/o_y; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
i_clk  in  1  pixel clock
i_rst  in  1  synchronous reset, active-high
i_en  in  1  advance raster; low freezes counters and all outputs
o_pix  out  1  pattern pixel, 0 whenever o_de=0
o_de  out  1  active-video enable
o_hs  out  1  horizontal sync (polarity HS_POL)
o_vs  out  1  vertical sync (polarity VS_POL)
o_x  out  CW  column of the current output pixel (valid when o_de=1)
o_y  out  CW  line of the current output pixel
o_sof  out  1  one-cycle strobe with first active pixel of frame (x=0,y=0)

Behaviour:
- One clock (i_clk); reset synchronous, active-high (i_rst). All outputs registered.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise (localparams).
- h_cnt: 0..H_TOTAL-1, +1 per enabled cycle, wraps to 0. v_cnt: +1 when h_cnt wraps; wraps to 0 from V_TOTAL-1 on the same cycle.
- Horizontal regions by h_cnt: active [0,H_ACTIVE-1], FP, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], BP. Vertical regions identical on v_cnt.
- de = h_active && v_active. hs = HS_POL when h in sync, else ~HS_POL. vs = VS_POL when v in sync (whole lines, changes at h_cnt=0), else ~VS_POL.
- pix = de & (x[CHECK_LOG2] ^ y[CHECK_LOG2]).
- Latency: outputs in cycle n+1 reflect counters in cycle n. o_x/o_y equal the h_cnt/v_cnt that produced them.
- sof = (h_cnt==0 && v_cnt==0), registered with the rest.
- Reset: h_cnt=v_cnt=0; o_de=0, o_pix=0, o_sof=0, o_hs=~HS_POL, o_vs=~VS_POL, o_x=o_y=0. First enabled cycle after reset evaluates (0,0), so o_sof=1 and o_de=1 on the second enabled cycle after reset release.
- i_en=0: counters and every output register hold; no strobe is re-issued. Resumes exactly where frozen.
- Reset mid-frame: restarts at (0,0) next cycle regardless of i_en. Reset has priority over i_en.
- Parameters of 0 are illegal for H_ACTIVE, V_ACTIVE, H_SYNC, V_SYNC. Porches may be 0.

Optional Feature:
DVI_TIMING_BORDER_EN: when defined, o_pix is forced to 1 on active pixels with x==0, x==H_ACTIVE-1, y==0 or y==V_ACTIVE-1 (a 1-pixel frame around the checkerboard). When undefined, o_pix is the pure checkerboard. Timing is identical either way.

Decomposition:
- Package dvi_pkg: default 640x480 timing constants, H_TOTAL/V_TOTAL helper functions, and sync polarity constants, all shared with dvi_encoder benches.
- One sub-module is natural: dvi_raster_cnt (h/v counters with enable, wrap and region flags). Pattern and output registers stay in the top.

Test Plan:
- Small config (H 4/1/2/1, V 3/1/1/1, HS_POL=VS_POL=0): release reset -> o_sof=1 and o_de=1 on 2nd cycle. o_de is high 4 of every 8 clocks. o_hs is low at h_cnt 5..6 (outputs lag one cycle). Frame period is 48 clocks.
- Same config, over a full frame -> o_vs is low for exactly 8 consecutive clocks (line 4) and toggles at line boundaries only. o_de=0 on lines 3..5.
- CHECK_LOG2=1, H_ACTIVE=8 -> line 0 o_pix = 0,0,1,1,0,0,1,1. Line 2 is inverted. o_pix=0 in all blanking cycles.
- Drop i_en for 5 cycles mid-line at x=2 -> all outputs are frozen for 5 cycles. After i_en returns, x=3 follows with no skip or repeat.
- Assert i_rst at (x=2,y=1) for one cycle -> next cycle shows reset values. The cycle after that shows o_sof=1, o_x=0, o_y=0.
- DVI_TIMING_BORDER_EN defined, CHECK_LOG2=5, small config -> every active pixel on the edge is 1. Interior pixels equal the checkerboard value.
